// File: rtl/norm_seq.sv
// -----------------------------------------------------------------------------
// norm_seq
// Multi-cycle normalisation sequencer for the FPU back end. A raw mantissa /
// exponent pair is accepted, then the mantissa is left-justified so that its
// MSB is 1. The scan walks the mantissa in fixed 10-bit windows through one
// shared 10-bit leading-zero counter, decrementing the exponent by the shift
// applied at each step. If a step would take the exponent below 1 the result
// is flushed to zero and flagged as underflow.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   in_valid   operand valid
//   in_ready   block can accept (idle)
//   in_mant    unnormalised mantissa (MANT_W bits, hidden bit included)
//   in_exp     biased exponent of in_mant (EXP_W bits, unsigned)
//   out_valid  result valid (held until out_ready)
//   out_ready  downstream accepts result
//   out_mant   normalised mantissa (MSB set unless out_zero)
//   out_exp    adjusted exponent (>= 1 unless out_zero)
//   out_zero   result is zero (zero input or underflow flush)
//   out_uflow  result flushed because the exponent would drop below 1
//
// MANT_W must be at least the window width (10).
// -----------------------------------------------------------------------------
module norm_seq #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_uflow
);

    // Window width is fixed by the 10-bit input of the shared clz.
    localparam int unsigned WIN = 10;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              zero_q, zero_d;
    logic              uflow_q, uflow_d;

    // -------------------------------------------------------------------------
    // Scan datapath
    // -------------------------------------------------------------------------
    logic [WIN-1:0]   window;
    logic             win_nz;
    logic [WIN-1:0]   clz_in;
    logic [3:0]       clz_out;
    logic             clz_found;
    logic [3:0]       shamt;
    logic [EXP_W+3:0] shamt_ext;
    logic [EXP_W+3:0] exp_ext;
    logic             flush;

    assign window = mant_q[MANT_W-1 -: WIN];
    assign win_nz = |window;

    // The clz only sees a window when its result is actually consumed, so it
    // never has to produce a count for an all-zero input.
    assign clz_in = (state_q == StScan && win_nz) ? window : '0;

    // Shared 10-bit leading-zero counter: first set bit from the top.
    always_comb begin
        clz_out   = 4'd0;
        clz_found = 1'b0;
        for (int i = WIN - 1; i >= 0; i--) begin
            if (!clz_found && clz_in[i]) begin
                clz_out   = 4'(WIN - 1 - i);
                clz_found = 1'b1;
            end
        end
    end

    // An all-zero window skips the whole window; otherwise shift to the top.
    assign shamt = win_nz ? clz_out : 4'(WIN);

    // Compare in a widened domain so the check is exact for any EXP_W, and
    // before any subtraction, so the exponent can never wrap.
    assign shamt_ext = {{EXP_W{1'b0}}, shamt};
    assign exp_ext   = {4'b0000, exp_q};
    assign flush     = (shamt_ext >= exp_ext);

    // -------------------------------------------------------------------------
    // Next-state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        zero_d  = zero_q;
        uflow_d = uflow_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mant_d  = in_mant;
                    exp_d   = in_exp;
                    uflow_d = 1'b0;
                    if (in_mant == '0) begin
                        exp_d   = '0;
                        zero_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                if (flush) begin
                    mant_d  = '0;
                    exp_d   = '0;
                    zero_d  = 1'b1;
                    uflow_d = 1'b1;
                    state_d = StDone;
                end else begin
                    mant_d = mant_q << shamt;
                    // shamt < exp_q here, so it fits in EXP_W bits.
                    exp_d  = exp_q - EXP_W'(shamt);
                    if (win_nz) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_mant  = mant_q;
    assign out_exp   = exp_q;
    assign out_zero  = zero_q;
    assign out_uflow = uflow_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mant_q  <= '0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
            uflow_q <= uflow_d;
        end
    end

endmodule

// File: tb/tb_norm_seq.sv
// -----------------------------------------------------------------------------
// tb_norm_seq
// Scoreboard bench for norm_seq. The driver computes each expected result with
// a reference model and queues it; a separate monitor pops and compares when
// the DUT presents a result, also checking latency and output stability while
// out_ready is held low.
// -----------------------------------------------------------------------------
module tb_norm_seq;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_uflow;

    norm_seq #(
        .MANT_W(MANT_W),
        .EXP_W (EXP_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mant  (in_mant),
        .in_exp   (in_exp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mant (out_mant),
        .out_exp  (out_exp),
        .out_zero (out_zero),
        .out_uflow(out_uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              zero;
        logic              uflow;
        int                lat;
        int                t;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   rdy_mode   = 2;   // 0 random, 1 force low, 2 force high

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: normalisation by the total leading-zero count, with the
    // exponent charged one window (10) at a time, then the remainder.
    function automatic exp_t model(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e);
        exp_t r;
        int   lz;
        int   rem;
        int   cur;
        int   s;
        int   step;
        bit   fin;
        r.t = 0;
        if (m == '0) begin
            r.mant = '0; r.exp = '0; r.zero = 1'b1; r.uflow = 1'b0; r.lat = 1;
            return r;
        end
        lz = 0;
        for (int i = 0; i < MANT_W; i++) begin
            if (m[MANT_W-1-i]) begin
                lz = i;
                break;
            end
        end
        rem  = lz;
        cur  = int'(e);
        step = 0;
        fin  = 1'b0;
        while (!fin) begin
            step++;
            s = (rem >= 10) ? 10 : rem;
            if (s >= cur) begin
                r.mant = '0; r.exp = '0; r.zero = 1'b1; r.uflow = 1'b1; r.lat = step + 1;
                return r;
            end
            cur = cur - s;
            if (rem < 10) fin = 1'b1;
            else rem = rem - 10;
        end
        r.mant  = m << lz;
        r.exp   = EXP_W'(cur);
        r.zero  = 1'b0;
        r.uflow = 1'b0;
        r.lat   = step + 1;
        return r;
    endfunction

    // Issue one operand; called at a negedge, returns one negedge after accept.
    task automatic send(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e);
        exp_t r;
        int   n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        r   = model(m, e);
        r.t = cyc;
        sbq.push_back(r);
        @(negedge clk);
        in_valid = 1'b0;
        in_mant  = MANT_W'($urandom);   // must be ignored after accept
        in_exp   = EXP_W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", (sbq.size() == 0 && in_ready), 1);
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom % 3) != 0;
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor
    logic                            holding = 1'b0;
    logic [MANT_W+EXP_W+1:0]         held;
    exp_t                            mr;

    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            if (out_valid) begin
                check("in_ready_in_done", in_ready, 0);
                if (!holding) begin
                    if (sbq.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_output: got %0h/%0h expected none",
                                 out_mant, out_exp);
                    end else begin
                        mr = sbq.pop_front();
                        check("out_mant", out_mant, mr.mant);
                        check("out_exp", out_exp, mr.exp);
                        check("out_zero", out_zero, mr.zero);
                        check("out_uflow", out_uflow, mr.uflow);
                        check("latency", cyc - mr.t, mr.lat);
                    end
                    held    = {out_mant, out_exp, out_zero, out_uflow};
                    holding = 1'b1;
                end else begin
                    check("hold_stable", {out_mant, out_exp, out_zero, out_uflow}, held);
                end
                if (out_ready) holding = 1'b0;
            end
            if (sbq.size() != 0 && !holding && (cyc - sbq[0].t) > sbq[0].lat) begin
                compared++;
                mismatched++;
                $display("FAIL latency_timeout: no result after %0d cycles, expected %0d",
                         cyc - sbq[0].t, sbq[0].lat);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        logic [MANT_W-1:0] m;
        logic [EXP_W-1:0]  e;
        int                n;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_mant  = '0;
        in_exp   = '0;
        rdy_mode = 2;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {out_mant, out_exp, out_zero, out_uflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);

        // Directed cases
        send(24'h800000, 8'd100);
        send(24'h000400, 8'd100);
        send(24'h000001, 8'd100);
        send(24'h000000, 8'd55);
        send(24'h000001, 8'd5);
        send(24'h000400, 8'd13);    // exactly reaches 0 on second step -> flush
        send(24'h000400, 8'd14);    // lands on exponent 1
        send(24'h0003FF, 8'd0);     // exponent 0 with nonzero mantissa -> flush
        drain();

        // Backpressure: result must stay stable for several cycles
        rdy_mode = 1;
        send(24'h012345, 8'd200);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_reach_done", out_valid, 1);
        repeat (5) @(negedge clk);
        check("hold_still_valid", out_valid, 1);
        rdy_mode = 2;
        drain();

        // Randomized traffic
        rdy_mode = 0;
        for (int k = 0; k < 300; k++) begin
            m = MANT_W'($urandom) >> $urandom_range(0, MANT_W);
            if ($urandom % 10 == 0) m = '0;
            e = ($urandom % 2) ? EXP_W'($urandom_range(0, 30)) : EXP_W'($urandom_range(0, 255));
            send(m, e);
        end
        rdy_mode = 2;
        drain();

        // Reset in the middle of a scan discards the operand
        send(24'h000001, 8'd100);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_outputs", {out_mant, out_exp, out_zero, out_uflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("no_stale_output", out_valid, 0);
        end
        send(24'h000400, 8'd100);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
